// File: rtl/rx_buf_pkg.sv
// Shared constants for the UART receive block buffer.
// Default geometry and byte width used by rx_block_fifo and block_fifo.
package rx_buf_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_BLOCK_BYTES = 16;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/block_fifo.sv
// Show-ahead block FIFO; a write and a pop in the same cycle both succeed.
// A write to a full FIFO without a same-cycle pop is dropped and flagged.
module block_fifo
  import rx_buf_pkg::*;
#(
  parameter int WIDTH = BYTE_W * DEF_BLOCK_BYTES,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             pop;
  logic             push;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  assign pop  = rd_en && !empty;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset: rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/rx_block_fifo.sv
// Assembles UART bytes into fixed-size blocks and queues them.
// Define RX_BLOCK_FLUSH_EN to let flush close a partial block.
module rx_block_fifo
  import rx_buf_pkg::*;
#(
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       rx_byte,
  input  logic                             rx_done,
  input  logic                             flush,
  input  logic                             read_en,
  input  logic                             ovf_clr,
  output logic [8*BLOCK_BYTES-1:0]         block_out,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(DEPTH):0]           count,
  output logic [$clog2(BLOCK_BYTES):0]     pending,
  output logic                             overflow
);
  localparam int W  = BYTE_W * BLOCK_BYTES;
  localparam int PW = $clog2(BLOCK_BYTES) + 1;

  logic [W-1:0]  asm_q;
  logic [W-1:0]  asm_n;
  logic [PW-1:0] pend_q;
  logic [PW-1:0] fill;
  logic          done_blk;
  logic          wr;
  logic [W-1:0]  wr_data;
  logic          drop;
  logic          ovf_q;

  // Bytes enter at the bottom so the first byte ends up at the top.
  assign asm_n    = rx_done ? {asm_q[W-BYTE_W-1:0], rx_byte} : asm_q;
  assign fill     = pend_q + PW'(rx_done);
  assign done_blk = (fill == PW'(BLOCK_BYTES));

`ifdef RX_BLOCK_FLUSH_EN
  int sh;
  assign sh      = BYTE_W * (BLOCK_BYTES - int'(fill));
  assign wr      = done_blk || (flush && (fill != '0));
  assign wr_data = asm_n << sh;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign wr      = done_blk;
  assign wr_data = asm_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q  <= '0;
      pend_q <= '0;
    end else if (wr) begin
      asm_q  <= '0;
      pend_q <= '0;
    end else begin
      asm_q  <= asm_n;
      pend_q <= fill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  block_fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr),
    .wr_data (wr_data),
    .rd_en   (read_en),
    .rd_data (block_out),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .drop    (drop)
  );

  assign pending  = pend_q;
  assign overflow = ovf_q;
endmodule
